// File: rtl/stream_capture_pkg.sv
// Shared types and constants for the stream capture controller and its port writers.
package stream_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [3:0] CSR_CTRL      = 4'd0;
    localparam logic [3:0] CSR_STATUS    = 4'd1;
    localparam logic [3:0] CSR_LIMIT     = 4'd2;
    localparam logic [3:0] CSR_PORT0_CNT = 4'd3;
    localparam logic [3:0] CSR_PORT1_CNT = 4'd4;
    localparam logic [3:0] CSR_TS_LO     = 4'd5;

    localparam int CTRL_START     = 0;
    localparam int CTRL_STOP      = 1;
    localparam int CTRL_SNOOP_RST = 2;
    localparam int CTRL_WRAP      = 3;

    localparam int TAG_W = 28;
    localparam logic [TAG_W-1:0] TAG_PORT0 = 28'h000f00a;
    localparam logic [TAG_W-1:0] TAG_PORT1 = 28'h000f00b;

endpackage

// File: rtl/capture_port_wr.sv
// Per-port capture writer: word count, write pointer, full flag and registered RAM write.
// Latency: 1 cycle beat-to-write. No backpressure: beats are dropped when disabled or full.
module capture_port_wr
    import stream_capture_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int ST_W   = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              wrap,
    input  logic [ADDR_W-1:0] limit,
    input  logic [TAG_W-1:0]  tag,
    input  logic [ST_W-1:0]   st_data,
    input  logic              st_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_writedata,
    output logic              mem_write,
    output logic [ADDR_W:0]   cnt,
    output logic              full
);

    logic [ADDR_W:0]   cnt_q, cnt_d, limit_ext;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_address_q, mem_address_d;
    logic [63:0]       mem_writedata_q, mem_writedata_d;
    logic              mem_write_q, mem_write_d, full_q, full_d;
    logic              take, at_end;

    always_comb begin
        // A LIMIT of zero means the full 2^ADDR_W address space.
        limit_ext       = (limit == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, limit};
        at_end          = ({1'b0, addr_q} == (limit_ext - (ADDR_W+1)'(1)));
        take            = en && st_valid && (wrap || !full_q);
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        full_d          = full_q;
        mem_write_d     = take && !clr;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        if (clr) begin
            cnt_d  = '0;
            addr_d = '0;
            full_d = 1'b0;
        end else if (take) begin
            mem_address_d   = addr_q;
            mem_writedata_d = {tag, st_data};
            addr_d          = at_end ? '0 : addr_q + ADDR_W'(1);
            if (cnt_q != limit_ext) begin
                cnt_d = cnt_q + (ADDR_W+1)'(1);
            end
            if (at_end) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q           <= '0;
            addr_q          <= '0;
            full_q          <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            full_q          <= full_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign mem_write     = mem_write_q;
    assign cnt           = cnt_q;
    assign full          = full_q;

endmodule

// File: rtl/stream_capture_ctrl.sv
// Two-port stream capture controller: CSR-driven IDLE/CAPTURE/DONE sequencing, snoop reset pulse.
// Latency: RAM write 1 cycle after beat, CSR read data 1 cycle. No backpressure on streams.
// STREAM_CAPTURE_TIMESTAMP_EN swaps the fixed port tags for a 28-bit free-running cycle count.
module stream_capture_ctrl
    import stream_capture_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int ST_W          = 36,
    parameter int SNOOP_RST_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        csr_address,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    input  logic [ST_W-1:0]   port0_st_data,
    input  logic              port0_st_valid,
    input  logic [ST_W-1:0]   port1_st_data,
    input  logic              port1_st_valid,
    output logic [ADDR_W-1:0] port0_mem_address,
    output logic [63:0]       port0_mem_writedata,
    output logic              port0_mem_write,
    output logic [ADDR_W-1:0] port1_mem_address,
    output logic [63:0]       port1_mem_writedata,
    output logic              port1_mem_write,
    output logic              snoop_reset
);

    localparam int SNOOP_W = $clog2(SNOOP_RST_CYC + 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  limit_q, limit_d;
    logic               wrap_q, wrap_d;
    logic [SNOOP_W-1:0] snoop_cnt_q, snoop_cnt_d;
    logic [31:0]        csr_readdata_q, csr_readdata_d;
    logic               ctrl_wr, start, stop, clr, capturing;
    logic [ADDR_W:0]    port0_cnt, port1_cnt;
    logic               port0_full, port1_full;
    logic [TAG_W-1:0]   tag0, tag1;
    logic [31:0]        ts_rd;
    logic               unused_wdata;

`ifdef STREAM_CAPTURE_TIMESTAMP_EN
    logic [TAG_W-1:0] ts_q, ts_d;
    assign ts_d = ts_q + TAG_W'(1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_d;
    end
    assign tag0  = ts_q;
    assign tag1  = ts_q;
    assign ts_rd = 32'(ts_q);
`else
    assign tag0  = TAG_PORT0;
    assign tag1  = TAG_PORT1;
    assign ts_rd = '0;
`endif

    assign unused_wdata = ^csr_writedata;
    assign capturing    = (state_q == ST_CAPTURE);

    always_comb begin
        ctrl_wr = csr_write && (csr_address == CSR_CTRL);
        start   = ctrl_wr && csr_writedata[CTRL_START];
        stop    = ctrl_wr && csr_writedata[CTRL_STOP];
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            // STOP dominates START when both arrive in one write.
            ST_IDLE, ST_DONE: begin
                if (start && !stop) begin
                    state_d = ST_CAPTURE;
                    clr     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (stop || (!wrap_q && port0_full && port1_full)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        limit_d     = limit_q;
        wrap_d      = wrap_q;
        snoop_cnt_d = snoop_cnt_q;
        if (!capturing && csr_write && (csr_address == CSR_LIMIT)) begin
            limit_d = csr_writedata[ADDR_W-1:0];
        end
        if (!capturing && ctrl_wr) begin
            wrap_d = csr_writedata[CTRL_WRAP];
        end
        if (ctrl_wr && csr_writedata[CTRL_SNOOP_RST]) begin
            snoop_cnt_d = SNOOP_W'(SNOOP_RST_CYC);
        end else if (snoop_cnt_q != '0) begin
            snoop_cnt_d = snoop_cnt_q - SNOOP_W'(1);
        end

        csr_readdata_d = '0;
        if (csr_read) begin
            case (csr_address)
                CSR_CTRL:      csr_readdata_d[CTRL_WRAP] = wrap_q;
                CSR_STATUS:    csr_readdata_d[3:0] = {port1_full, port0_full, state_q};
                CSR_LIMIT:     csr_readdata_d[ADDR_W-1:0] = limit_q;
                CSR_PORT0_CNT: csr_readdata_d = 32'(port0_cnt);
                CSR_PORT1_CNT: csr_readdata_d = 32'(port1_cnt);
                CSR_TS_LO:     csr_readdata_d = ts_rd;
                default:       csr_readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            limit_q        <= '0;
            wrap_q         <= 1'b0;
            snoop_cnt_q    <= '0;
            csr_readdata_q <= '0;
        end else begin
            state_q        <= state_d;
            limit_q        <= limit_d;
            wrap_q         <= wrap_d;
            snoop_cnt_q    <= snoop_cnt_d;
            csr_readdata_q <= csr_readdata_d;
        end
    end

    assign csr_readdata = csr_readdata_q;
    assign snoop_reset  = (snoop_cnt_q != '0);

    capture_port_wr #(.ADDR_W(ADDR_W), .ST_W(ST_W)) u_port0 (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .en            (capturing),
        .wrap          (wrap_q),
        .limit         (limit_q),
        .tag           (tag0),
        .st_data       (port0_st_data),
        .st_valid      (port0_st_valid),
        .mem_address   (port0_mem_address),
        .mem_writedata (port0_mem_writedata),
        .mem_write     (port0_mem_write),
        .cnt           (port0_cnt),
        .full          (port0_full)
    );

    capture_port_wr #(.ADDR_W(ADDR_W), .ST_W(ST_W)) u_port1 (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .en            (capturing),
        .wrap          (wrap_q),
        .limit         (limit_q),
        .tag           (tag1),
        .st_data       (port1_st_data),
        .st_valid      (port1_st_valid),
        .mem_address   (port1_mem_address),
        .mem_writedata (port1_mem_writedata),
        .mem_write     (port1_mem_write),
        .cnt           (port1_cnt),
        .full          (port1_full)
    );

endmodule

// File: tb/tb_stream_capture_ctrl.sv
// Directed bench for stream_capture_ctrl; capture RAM writes are scored against a queue of expected writes.
module tb_stream_capture_ctrl;

    localparam int ADDR_W        = 20;
    localparam int ST_W          = 36;
    localparam int SNOOP_RST_CYC = 16;
    localparam logic [27:0] TAG0 = 28'h000f00a;
    localparam logic [27:0] TAG1 = 28'h000f00b;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        csr_address = '0;
    logic              csr_write = 1'b0;
    logic              csr_read = 1'b0;
    logic [31:0]       csr_writedata = '0;
    logic [31:0]       csr_readdata;
    logic [ST_W-1:0]   port0_st_data = '0;
    logic              port0_st_valid = 1'b0;
    logic [ST_W-1:0]   port1_st_data = '0;
    logic              port1_st_valid = 1'b0;
    logic [ADDR_W-1:0] port0_mem_address, port1_mem_address;
    logic [63:0]       port0_mem_writedata, port1_mem_writedata;
    logic              port0_mem_write, port1_mem_write;
    logic              snoop_reset;

    stream_capture_ctrl #(.ADDR_W(ADDR_W), .ST_W(ST_W), .SNOOP_RST_CYC(SNOOP_RST_CYC)) dut (
        .clk                 (clk),
        .reset               (reset),
        .csr_address         (csr_address),
        .csr_write           (csr_write),
        .csr_read            (csr_read),
        .csr_writedata       (csr_writedata),
        .csr_readdata        (csr_readdata),
        .port0_st_data       (port0_st_data),
        .port0_st_valid      (port0_st_valid),
        .port1_st_data       (port1_st_data),
        .port1_st_valid      (port1_st_valid),
        .port0_mem_address   (port0_mem_address),
        .port0_mem_writedata (port0_mem_writedata),
        .port0_mem_write     (port0_mem_write),
        .port1_mem_address   (port1_mem_address),
        .port1_mem_writedata (port1_mem_writedata),
        .port1_mem_write     (port1_mem_write),
        .snoop_reset         (snoop_reset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  checks = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        tick();
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        csr_address = a;
        csr_read    = 1'b1;
        tick();
        csr_read    = 1'b0;
        check(tag, {32'b0, csr_readdata}, {32'b0, exp});
    endtask

    // Scoreboard: every observed RAM write must match the head of its port's queue.
    logic        prev_w0 = 1'b0, prev_w1 = 1'b0;
    logic [27:0] prev_t0 = '0, prev_t1 = '0;
    always @(negedge clk) begin
        wr_t e;
        if (port0_mem_write) begin
            checks++;
            assert (q0.size() > 0) else begin
                failures++;
                $error("FAIL p0_unexpected_write observed_addr=0x%0h expected=no write", port0_mem_address);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("p0_addr", {44'b0, port0_mem_address}, {44'b0, e.addr});
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
                check("p0_data", {28'b0, port0_mem_writedata[35:0]}, {28'b0, e.data[35:0]});
                if (prev_w0) check("p0_ts_step", {36'b0, port0_mem_writedata[63:36]}, {36'b0, prev_t0 + 28'd1});
`else
                check("p0_data", port0_mem_writedata, e.data);
`endif
            end
        end
        if (port1_mem_write) begin
            checks++;
            assert (q1.size() > 0) else begin
                failures++;
                $error("FAIL p1_unexpected_write observed_addr=0x%0h expected=no write", port1_mem_address);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("p1_addr", {44'b0, port1_mem_address}, {44'b0, e.addr});
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
                check("p1_data", {28'b0, port1_mem_writedata[35:0]}, {28'b0, e.data[35:0]});
                if (prev_w1) check("p1_ts_step", {36'b0, port1_mem_writedata[63:36]}, {36'b0, prev_t1 + 28'd1});
`else
                check("p1_data", port1_mem_writedata, e.data);
`endif
            end
        end
        prev_w0 = port0_mem_write;
        prev_t0 = port0_mem_writedata[63:36];
        prev_w1 = port1_mem_write;
        prev_t1 = port1_mem_writedata[63:36];
    end

    initial begin
        int hi;

        // Reset state
        tick(); tick();
        check("rst_mem_write0", {63'b0, port0_mem_write}, 64'd0);
        check("rst_mem_write1", {63'b0, port1_mem_write}, 64'd0);
        check("rst_mem_addr0", {44'b0, port0_mem_address}, 64'd0);
        check("rst_snoop", {63'b0, snoop_reset}, 64'd0);
        check("rst_readdata", {32'b0, csr_readdata}, 64'd0);
        reset = 1'b0;
        tick();
        csr_rd_check("rst_status", 4'd1, 32'h0);
        csr_rd_check("rst_limit", 4'd2, 32'h0);
        csr_rd_check("rst_port0_cnt", 4'd3, 32'h0);
        csr_rd_check("unmapped_rd", 4'd9, 32'h0);
`ifndef STREAM_CAPTURE_TIMESTAMP_EN
        csr_rd_check("ts_lo_zero", 4'd5, 32'h0);
`endif

        // START and STOP together in IDLE: no capture, beats dropped
        csr_wr(4'd0, 32'h3);
        port0_st_valid = 1'b1;
        port0_st_data  = 36'h0_0000_0055;
        tick(); tick();
        port0_st_valid = 1'b0;
        csr_rd_check("start_stop_idle", 4'd1, 32'h0);

        // Non-wrap LIMIT=4: port0 fills after 4 beats, remaining beats dropped
        csr_wr(4'd2, 32'd4);
        csr_rd_check("limit_4", 4'd2, 32'd4);
        csr_wr(4'd0, 32'h1);
        port0_st_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            port0_st_data = 36'h100 + 36'(i);
            if (i < 4) q0.push_back({ADDR_W'(i), TAG0, 36'h100 + 36'(i)});
            tick();
        end
        port0_st_valid = 1'b0;
        tick(); tick();
        csr_rd_check("status_p0_full", 4'd1, 32'h5);
        csr_rd_check("port0_cnt_4", 4'd3, 32'd4);
        port1_st_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            port1_st_data = 36'hA00 + 36'(i);
            q1.push_back({ADDR_W'(i), TAG1, 36'hA00 + 36'(i)});
            tick();
        end
        port1_st_valid = 1'b0;
        tick(); tick(); tick();
        csr_rd_check("status_done_both_full", 4'd1, 32'hE);
        csr_rd_check("port1_cnt_4", 4'd4, 32'd4);

        // Wrap mode LIMIT=3: addresses cycle, count saturates, LIMIT locked during capture
        csr_wr(4'd2, 32'd3);
        csr_wr(4'd0, 32'h9);
        port1_st_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            port1_st_data = 36'hB00 + 36'(i);
            q1.push_back({ADDR_W'(i % 3), TAG1, 36'hB00 + 36'(i)});
            tick();
        end
        port1_st_valid = 1'b0;
        tick();
        csr_wr(4'd2, 32'd7);
        csr_rd_check("limit_locked", 4'd2, 32'd3);
        csr_rd_check("port1_cnt_sat", 4'd4, 32'd3);
        csr_rd_check("status_wrap_capture", 4'd1, 32'h9);
        csr_wr(4'd0, 32'h2);
        tick();
        csr_rd_check("status_after_stop", 4'd1, 32'hA);
        csr_rd_check("port0_cnt_cleared", 4'd3, 32'd0);

        // Snoop reset pulse: single, then retriggered at its 10th cycle
        csr_wr(4'd0, 32'h4);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (snoop_reset) hi++;
            tick();
        end
        check("snoop_len", 64'(hi), 64'd16);
        csr_wr(4'd0, 32'h4);
        hi = 0;
        for (int i = 0; i < 45; i++) begin
            if (snoop_reset) hi++;
            csr_address   = 4'd0;
            csr_writedata = 32'h4;
            csr_write     = (i == 9);
            tick();
        end
        csr_write = 1'b0;
        check("snoop_retrig_len", 64'(hi), 64'd26);
        csr_rd_check("status_after_snoop", 4'd1, 32'hA);

        // Reset mid-capture with valid held high
        csr_wr(4'd0, 32'h1);
        port0_st_valid = 1'b1;
        port0_st_data  = 36'hC00;
        q0.push_back({ADDR_W'(0), TAG0, 36'hC00});
        tick();
        port0_st_data  = 36'hC01;
        tick();
        #1;
        reset = 1'b1;
        #1;
        check("rst_abort_write", {63'b0, port0_mem_write}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_write", {63'b0, port0_mem_write}, 64'd0);
        end
        reset = 1'b0;
        port0_st_valid = 1'b0;
        tick();
        csr_rd_check("status_after_rst", 4'd1, 32'h0);
        csr_rd_check("port0_cnt_after_rst", 4'd3, 32'h0);
        csr_rd_check("limit_after_rst", 4'd2, 32'h0);

        tick(); tick();
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_capture_ctrl.md
STREAM_CAPTURE_CTRL -- requirements
Module: stream_capture_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  ADDR_W, 20, capture memory word-address width per port
  ST_W, 36, stream data width
  SNOOP_RST_CYC, 16, snoop_reset pulse length in clocks
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
  clk  in  1  single clock for all logic
  reset  in  1  asynchronous, active-high reset
  csr_address  in  4  CSR word select
  csr_write / csr_read  in  1  CSR strobes
  csr_writedata  in  32  CSR write data
  csr_readdata  out  32  CSR read data, read latency 1
  portN_st_data  in  ST_W  stream data, N = 0, 1
  portN_st_valid  in  1  stream beat qualifier, no backpressure
  portN_mem_address  out  ADDR_W  capture RAM word address
  portN_mem_writedata  out  64  {tag, portN_st_data}
  portN_mem_write  out  1  capture RAM write strobe
  snoop_reset  out  1  reset pulse to upstream snoop logic

Function
REQ-003 CSR map: 0 CTRL (write-only pulses: b0 START, b1 STOP, b2 SNOOP_RST; b3 WRAP is sticky), 1 STATUS (b1:0 state, b2 port0 full, b3 port1 full), 2 LIMIT (ADDR_W bits; 0 = 2^ADDR_W words), 3 PORT0_CNT, 4 PORT1_CNT, 5 TS_LO (macro only); unmapped addresses read 0, writes ignored.
REQ-004 FSM states: IDLE=0, CAPTURE=1, DONE=2.
REQ-005 IDLE/DONE --START--> CAPTURE; both port counts and full flags cleared on entry.
REQ-006 CAPTURE --STOP--> DONE; START and STOP in the same write: STOP wins, no transition out of IDLE.
REQ-007 Non-wrap mode: each port stops writing when its count = LIMIT (full flag set); CAPTURE --> DONE when both ports full.
REQ-008 Wrap mode: address returns to 0 after LIMIT-1; count saturates at LIMIT, full flag set on first wrap; exit only via STOP.
REQ-009 Write path registered, 1-cycle latency: valid beat at cycle t in CAPTURE and port not full (non-wrap) -> mem_write=1, address=count, data captured at t+1.
REQ-010 Address increments only on written beats; ports are independent.
REQ-011 Final beat filling a port is written; DONE entered the cycle after the last port fills; beats in that cycle not written.
REQ-012 Writes to LIMIT or WRAP while in CAPTURE SHALL be ignored.
REQ-013 SNOOP_RST write -> snoop_reset high for exactly SNOOP_RST_CYC cycles starting next cycle; re-trigger during pulse restarts the count; FSM unaffected.
REQ-014 Tag (no macro): port0 = 28'h000f00a, port1 = 28'h000f00b.

Reset
REQ-015 On reset assertion: state=IDLE, counts=0, full flags=0, LIMIT=0, WRAP=0, all mem_write=0, mem_address=0, snoop_reset=0, csr_readdata=0.
REQ-016 Reset mid-CAPTURE aborts immediately; no further mem_write after reset assertion.

Configuration
REQ-017 Macro STREAM_CAPTURE_TIMESTAMP_EN defined: a 28-bit free-running cycle counter (reset 0, wraps) replaces the tag in writedata[63:36] and TS_LO reads its value; undefined: fixed tags per REQ-014 and TS_LO reads 0.

Structure
REQ-018 Shared package stream_capture_pkg holds state enum, CSR address constants, CTRL bit indices and tag constants.
REQ-019 One sub-module capture_port_wr, instantiated per port: count/address/full/write-strobe logic.

Verification
REQ-020 LIMIT=4, START, 6 port0 valids -> addresses 0..3 written, full0=1, no 5th write; STATE stays CAPTURE until port1 fills.
REQ-021 LIMIT=3, WRAP=1, START, 7 port1 valids -> addresses 0,1,2,0,1,2,0; PORT1_CNT=3; STOP -> STATE=2.
REQ-022 CTRL=0x3 in IDLE -> STATE remains 0, no mem_write.
REQ-023 CTRL=0x4 -> snoop_reset high exactly 16 cycles; second 0x4 at cycle 10 -> high 26 cycles total.
REQ-024 Reset asserted mid-capture with valid high -> mem_write low same cycle, STATUS reads 0 after release.
REQ-025 With macro: writedata[63:36] of consecutive-cycle beats differ by 1; without: port0 upper bits 0x000f00a.
